// File: rtl/alu_operand_stack.sv
// alu_operand_stack
//   Operand stack sitting between the instruction sequencer and the 16-bit ALU.
//   PUSH/POP/OP/NOP commands arrive on a valid/ready handshake. An OP loads the
//   ALU operand registers from the top entries, waits one CALC cycle for the
//   combinational ALU result, then writes that result back onto the stack.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready is low during CALC)
//   cmd_op              00 PUSH, 01 POP, 10 OP, 11 NOP
//   cmd_data            PUSH value
//   cmd_func            ALU function for OP, bit 4 set means unary
//   alu_a/alu_b/alu_f   registered ALU inputs
//   alu_s               ALU result, consumed only in CALC
//   top, depth          top-of-stack (0 when empty) and entry count
//   err_over/err_under  sticky error flags, cleared by clr_err
module alu_operand_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [W-1:0]  cmd_data,
  input  logic [4:0]    cmd_func,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [4:0]    alu_f,
  input  logic [W-1:0]  alu_s,
  output logic [W-1:0]  top,
  output logic [AW:0]   depth,
  output logic          err_over,
  output logic          err_under,
  input  logic          clr_err
);

  localparam logic [1:0]  OP_PUSH = 2'b00;
  localparam logic [1:0]  OP_POP  = 2'b01;
  localparam logic [1:0]  OP_ALU  = 2'b10;
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {IDLE, CALC} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   mem [DEPTH];
  logic [AW:0]    depth_reg, depth_next;
  logic [W-1:0]   top_reg, top_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [4:0]     f_reg, f_next;
  logic           over_reg, over_next;
  logic           under_reg, under_next;

  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [W-1:0]   wr_data;
  logic [AW:0]    idx_top, idx_below;
  logic [W-1:0]   below_val;

  // top lives in its own register; the RAM only needs to supply the entry
  // underneath it (for POP and binary OP operand a).
  assign idx_top   = depth_reg - (AW+1)'(1);
  assign idx_below = depth_reg - (AW+1)'(2);
  assign below_val = mem[idx_below[AW-1:0]];

  always_comb begin
    state_next = state_reg;
    depth_next = depth_reg;
    top_next   = top_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    f_next     = f_reg;
    // clear first so that an error raised in the same cycle overrides it
    over_next  = over_reg  & ~clr_err;
    under_next = under_reg & ~clr_err;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    cmd_ready  = (state_reg == IDLE);

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUSH: begin
              if (depth_reg != FULL) begin
                wr_en      = 1'b1;
                wr_addr    = depth_reg[AW-1:0];
                wr_data    = cmd_data;
                top_next   = cmd_data;
                depth_next = depth_reg + (AW+1)'(1);
              end else begin
                over_next = 1'b1;
              end
            end
            OP_POP: begin
              if (depth_reg != '0) begin
                depth_next = idx_top;
                top_next   = (depth_reg >= (AW+1)'(2)) ? below_val : '0;
              end else begin
                under_next = 1'b1;
              end
            end
            OP_ALU: begin
              if (cmd_func[4]) begin
                if (depth_reg != '0) begin
                  a_next     = top_reg;
                  b_next     = '0;
                  f_next     = cmd_func;
                  state_next = CALC;
                end else begin
                  under_next = 1'b1;
                end
              end else begin
                if (depth_reg >= (AW+1)'(2)) begin
                  a_next     = below_val;
                  b_next     = top_reg;
                  f_next     = cmd_func;
                  state_next = CALC;
                end else begin
                  under_next = 1'b1;
                end
              end
            end
            default: ;  // NOP
          endcase
        end
      end
      CALC: begin
        state_next = IDLE;
        top_next   = alu_s;
        wr_en      = 1'b1;
        wr_data    = alu_s;
        if (f_reg[4]) begin
          wr_addr = idx_top[AW-1:0];
        end else begin
          // the two operands collapse into one entry at the lower slot
          wr_addr    = idx_below[AW-1:0];
          depth_next = idx_top;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      depth_reg <= '0;
      top_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      f_reg     <= '0;
      over_reg  <= 1'b0;
      under_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      depth_reg <= depth_next;
      top_reg   <= top_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      f_reg     <= f_next;
      over_reg  <= over_next;
      under_reg <= under_next;
    end
  end

  // Stack storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_f     = f_reg;
  assign top       = top_reg;
  assign depth     = depth_reg;
  assign err_over  = over_reg;
  assign err_under = under_reg;

endmodule

// File: tb/tb_alu_operand_stack.sv
module tb_alu_operand_stack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [4:0]  cmd_func;
  logic [15:0] alu_a, alu_b, alu_s, top;
  logic [4:0]  alu_f;
  logic [4:0]  depth;
  logic        err_over, err_under, clr_err;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural reference state
  logic signed [15:0] q[$];
  logic               m_over, m_under;
  logic [15:0]        m_a, m_b;
  logic [4:0]         m_f;

  always #5 clk = ~clk;

  alu_operand_stack #(.W(16), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_func(cmd_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_s(alu_s),
    .top(top), .depth(depth), .err_over(err_over), .err_under(err_under),
    .clr_err(clr_err)
  );

  // Small ALU used both as the DUT's environment and by the reference model.
  function automatic logic [15:0] ref_alu(input logic [4:0] f,
                                          input logic signed [15:0] a,
                                          input logic signed [15:0] b);
    case (f)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return 16'(a * b);
      5'd15:   return (a < b) ? 16'd1 : 16'd0;
      5'd16:   return -a;
      5'd17:   return ~a;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_s = ref_alu(alu_f, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_top();
    return (q.size() == 0) ? 16'd0 : q[q.size()-1];
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".top"}, 32'(top), 32'(m_top()));
    chk({tag, ".depth"}, 32'(depth), 32'(q.size()));
    chk({tag, ".err_over"}, 32'(err_over), 32'(m_over));
    chk({tag, ".err_under"}, 32'(err_under), 32'(m_under));
    chk({tag, ".alu_a"}, 32'(alu_a), 32'(m_a));
    chk({tag, ".alu_b"}, 32'(alu_b), 32'(m_b));
    chk({tag, ".alu_f"}, 32'(alu_f), 32'(m_f));
  endtask

  task automatic model_reset();
    q.delete();
    m_over = 0; m_under = 0; m_a = 0; m_b = 0; m_f = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset.ready", 32'(cmd_ready), 32'd1);
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] data,
                       input logic [4:0] func, input logic clr);
    logic calc;
    logic ev_over, ev_under;
    logic signed [15:0] ea, eb;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_func = func; clr_err = clr;
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    calc = 0; ev_over = 0; ev_under = 0; ea = 0; eb = 0;
    case (op)
      2'b00: if (q.size() == 16) ev_over = 1; else q.push_back(data);
      2'b01: if (q.size() == 0) ev_under = 1; else void'(q.pop_back());
      2'b10: begin
        if (func[4]) begin
          if (q.size() >= 1) begin calc = 1; ea = q[q.size()-1]; eb = 0; end
          else ev_under = 1;
        end else begin
          if (q.size() >= 2) begin calc = 1; ea = q[q.size()-2]; eb = q[q.size()-1]; end
          else ev_under = 1;
        end
      end
      default: ;
    endcase
    m_over  = (m_over  & ~clr) | ev_over;
    m_under = (m_under & ~clr) | ev_under;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'b11; clr_err = 1'b0;
    if (calc) begin
      m_a = ea; m_b = eb; m_f = func;
      chk("calc.ready", 32'(cmd_ready), 32'd0);
      chk("calc.alu_a", 32'(alu_a), 32'(m_a));
      chk("calc.alu_b", 32'(alu_b), 32'(m_b));
      chk("calc.alu_f", 32'(alu_f), 32'(m_f));
      if (func[4]) begin
        q[q.size()-1] = ref_alu(func, ea, eb);
      end else begin
        void'(q.pop_back());
        q[q.size()-1] = ref_alu(func, ea, eb);
      end
      @(posedge clk);
      #1;
    end
    chk("post.ready", 32'(cmd_ready), 32'd1);
    check_state("post");
    $display("cmd op=%0d data=%0d func=%0d clr=%0d -> top=%0d depth=%0d ovr=%0b und=%0b",
             op, $signed(data), func, clr, $signed(top), depth, err_over, err_under);
  endtask

  task automatic push(input logic signed [15:0] v); issue(2'b00, v, 5'd0, 1'b0); endtask
  task automatic alu_op(input logic [4:0] f); issue(2'b10, 16'd0, f, 1'b0); endtask

  initial begin
    logic [4:0] funcs [8];
    funcs = '{5'd0, 5'd1, 5'd2, 5'd15, 5'd16, 5'd17, 5'd5, 5'd20};
    rst_n = 1'b0; cmd_valid = 0; cmd_op = 2'b11; cmd_data = 0; cmd_func = 0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    reset_dut();

    // 1: SUB
    push(-16'sd3); push(16'sd1475); alu_op(5'b00001);
    chk("t1.top", 32'(top), 32'(16'hFA3A));  // -1478
    chk("t1.depth", 32'(depth), 32'd1);

    // 2: unary NEG
    reset_dut();
    push(-16'sd3); alu_op(5'b10000);
    chk("t2.top", 32'(top), 32'd3);
    chk("t2.alu_a", 32'(alu_a), 32'(16'hFFFD));

    // 3: MUL then LT
    reset_dut();
    push(-16'sd3); push(16'sd1475); alu_op(5'b00010);
    chk("t3.mul", 32'(top), 32'(16'hEEB7));  // -4425
    push(16'sd1); alu_op(5'b01111);
    chk("t3.lt", 32'(top), 32'd1);
    chk("t3.depth", 32'(depth), 32'd1);

    // 4: fill, overflow, clear racing an overflow, then clear
    reset_dut();
    for (int i = 0; i < 16; i++) push(16'(i));
    issue(2'b00, 16'd99, 5'd0, 1'b0);
    chk("t4.over", 32'(err_over), 32'd1);
    chk("t4.top", 32'(top), 32'd15);
    issue(2'b00, 16'd99, 5'd0, 1'b1);
    chk("t4.over_wins", 32'(err_over), 32'd1);
    issue(2'b11, 16'd0, 5'd0, 1'b1);
    chk("t4.clr", 32'(err_over), 32'd0);

    // 5: underflow on POP and on short OP
    reset_dut();
    issue(2'b01, 16'd0, 5'd0, 1'b0);
    chk("t5.under", 32'(err_under), 32'd1);
    push(16'sd7); alu_op(5'd0);
    chk("t5.top", 32'(top), 32'd7);
    chk("t5.under_kept", 32'(err_under), 32'd1);

    // 6: reset during CALC aborts the write-back
    reset_dut();
    push(16'sd5); push(16'sd6);
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'b10; cmd_func = 5'd0;
    @(posedge clk);
    #1;
    cmd_valid = 0; cmd_op = 2'b11;
    chk("t6.in_calc", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6.ready", 32'(cmd_ready), 32'd1);
    check_state("t6");
    @(posedge clk);
    #1;
    check_state("t6.after_edge");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      issue(op, 16'($urandom), funcs[$urandom_range(0, 7)], ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
